// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: NUM_CH independent 50% square waves
// with rise strobes, runtime half-period load, global enable and global re-align.
module clk_div_lane #(
    parameter int CNT_W        = 25,
    parameter int DEFAULT_HALF = 8333333
) (
    input  logic             inp_clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    output logic             out_clk,
    output logic             tick
);
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge inp_clk) begin
        if (!rst_n) begin
            half    <= CNT_W'(DEFAULT_HALF);
            cnt     <= '0;
            out_clk <= 1'b0;
            tick    <= 1'b0;
        end else begin
            // half is written even when sync wins the cnt/out_clk update
            if (ld) half <= ld_val;
            if (sync) begin
                cnt     <= '0;
                out_clk <= 1'b0;
                tick    <= 1'b0;
            end else if (ld) begin
                cnt  <= '0;
                tick <= 1'b0;
            end else if (en) begin
                if (cnt >= half) begin
                    cnt     <= '0;
                    out_clk <= ~out_clk;
                    tick    <= ~out_clk;
                end else begin
                    cnt  <= cnt + CNT_W'(1);
                    tick <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
            end
        end
    end
endmodule

module clk_div_multi #(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = 25,
    parameter int DEFAULT_HALF = 8333333
) (
    input  logic              inp_clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync,
    input  logic              ld,
    input  logic [2:0]        ld_ch,
    input  logic [CNT_W-1:0]  ld_val,
    output logic [NUM_CH-1:0] out_clk,
    output logic [NUM_CH-1:0] tick
);
    // An out-of-range ld_ch matches no lane, so the load is dropped
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
        clk_div_lane #(
            .CNT_W       (CNT_W),
            .DEFAULT_HALF(DEFAULT_HALF)
        ) u_lane (
            .inp_clk(inp_clk),
            .rst_n  (rst_n),
            .en     (en),
            .sync   (sync),
            .ld     (ld && (ld_ch == 3'(gi))),
            .ld_val (ld_val),
            .out_clk(out_clk[gi]),
            .tick   (tick[gi])
        );
    end
endmodule
